des_out_serializer: RTL and testbench

- Downstream stage of the DES core controller. Captures every 64-bit `result` pulse the core emits and buffers it in a FIFO.
- The core cannot stall, so the FIFO decouples it from the consumer.
- Each buffered block is emitted as 8 bytes, MSB first, on a valid/ready byte stream toward the host link (UART/AXIS bridge).
- Overflow is detected, dropped blocks are counted, and a synchronous flush is provided.

---
 rtl/des_pkg.sv | 14 +
 rtl/des_out_fifo.sv | 65 ++++++
 rtl/des_out_serializer.sv | 147 ++++++++++++++
 tb/tb_des_out_serializer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared constants and FSM state type for the DES output serializer slice.
package des_pkg;

  localparam int DES_BLOCK_W     = 64;
  localparam int DES_BYTE_W      = 8;
  localparam int BYTES_PER_BLOCK = 8;
  localparam int BYTE_CNT_W      = $clog2(BYTES_PER_BLOCK);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_e;

endpackage

// File: rtl/des_out_fifo.sv
// Synchronous FIFO with occupancy level and synchronous flush.
// The read port shows the head entry combinationally; the caller must only assert rd_en when not empty.
module des_out_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;

  // Storage has no reset: only entries counted by r_level are ever read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (wr_en) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (rd_en) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({wr_en, rd_en})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  assign rd_data = r_mem[r_rptr];
  assign level   = r_level;
  assign full    = (r_level == LVL_FULL);
  assign empty   = (r_level == '0);

endmodule

// File: rtl/des_out_serializer.sv
// Buffers 64-bit DES result blocks and streams them out MSB-first as bytes over valid/ready.
// Optional `DES_OUT_DROPCNT_EN adds a saturating 16-bit dropped-block counter output.
module des_out_serializer
  import des_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [DES_BLOCK_W-1:0] result,
  input  logic                   result_valid,
  output logic [DES_BYTE_W-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [AW:0]            fifo_level,
  output logic                   overflow
`ifdef DES_OUT_DROPCNT_EN
  ,
  output logic [15:0]            drop_count
`endif
);

  localparam logic [BYTE_CNT_W-1:0] LAST_IDX = BYTE_CNT_W'(BYTES_PER_BLOCK - 1);
  localparam logic [BYTE_CNT_W-1:0] CNT_ONE  = BYTE_CNT_W'(1);

  state_e                  r_state;
  state_e                  w_nextState;
  logic [DES_BLOCK_W-1:0]  r_shReg;
  logic [BYTE_CNT_W-1:0]   r_cnt;
  logic                    r_overflow;

  logic                    w_handshake;
  logic                    w_lastByte;
  logic                    w_pop;
  logic                    w_canWrite;
  logic                    w_wr;
  logic                    w_drop;
  logic [DES_BLOCK_W-1:0]  w_fifoData;
  logic                    w_full;
  logic                    w_empty;

  assign w_lastByte  = (r_cnt == LAST_IDX);
  assign w_handshake = (r_state == S_SEND) && out_ready;
  assign w_pop       = !flush && !w_empty &&
                       ((r_state == S_IDLE) || (w_handshake && w_lastByte));
  // A full FIFO can still take a block when the head leaves on the same edge.
  assign w_canWrite  = !w_full || w_pop;
  assign w_wr        = result_valid && !flush && w_canWrite;
  assign w_drop      = result_valid && !flush && !w_canWrite;

  des_out_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DES_BLOCK_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wr_en   (w_wr),
    .wr_data (result),
    .rd_en   (w_pop),
    .rd_data (w_fifoData),
    .level   (fifo_level),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (flush) begin
      w_nextState = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (!w_empty) w_nextState = S_SEND;
        S_SEND:  if (w_handshake && w_lastByte && w_empty) w_nextState = S_IDLE;
        default: w_nextState = S_IDLE;
      endcase
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    if (r_state == S_SEND) begin
      out_valid = 1'b1;
      out_last  = w_lastByte;
      out_data  = r_shReg[DES_BLOCK_W-1 -: DES_BYTE_W];
    end
  end

  // The final shift empties the register, so an idle serializer holds zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shReg <= '0;
      r_cnt   <= '0;
    end else if (flush) begin
      r_shReg <= '0;
      r_cnt   <= '0;
    end else if (w_pop) begin
      r_shReg <= w_fifoData;
      r_cnt   <= '0;
    end else if (w_handshake) begin
      r_shReg <= {r_shReg[DES_BLOCK_W-DES_BYTE_W-1:0], {DES_BYTE_W{1'b0}}};
      r_cnt   <= r_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;

`ifdef DES_OUT_DROPCNT_EN
  logic [15:0] r_dropCount;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dropCount <= '0;
    end else if (flush) begin
      r_dropCount <= '0;
    end else if (w_drop && (r_dropCount != 16'hFFFF)) begin
      r_dropCount <= r_dropCount + 16'd1;
    end
  end

  assign drop_count = r_dropCount;
`endif

endmodule

// File: tb/tb_des_out_serializer.sv
// Self-checking bench for des_out_serializer: queue-based block model compared every cycle, plus directed literal checks.
module tb_des_out_serializer;

  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [63:0] result = '0;
  logic        result_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic [AW:0] fifo_level;
  logic        overflow;
`ifdef DES_OUT_DROPCNT_EN
  logic [15:0] drop_count;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  des_out_serializer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .result       (result),
    .result_valid (result_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .fifo_level   (fifo_level),
    .overflow     (overflow)
`ifdef DES_OUT_DROPCNT_EN
    ,
    .drop_count   (drop_count)
`endif
  );

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual == expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: a queue of buffered blocks plus the block currently being sent.
  logic [63:0] mQ[$];
  bit          mBusy = 1'b0;
  logic [63:0] mCur = '0;
  int          mIdx = 0;
  bit          mOvf = 1'b0;
  int          mDrop = 0;

  always @(posedge clk or negedge rst) begin : modelProc
    bit hs;
    bit done;
    bit pop;
    bit acc;
    int sz;
    if (!rst || flush) begin
      mQ.delete();
      mBusy = 1'b0;
      mCur  = '0;
      mIdx  = 0;
      mOvf  = 1'b0;
      mDrop = 0;
    end else begin
      sz   = mQ.size();
      hs   = mBusy && out_ready;
      done = hs && (mIdx == 7);
      pop  = (sz > 0) && (!mBusy || done);
      acc  = result_valid && ((sz < DEPTH) || pop);
      if (result_valid && !acc) begin
        mOvf = 1'b1;
        if (mDrop < 65535) mDrop++;
      end
      if (pop) begin
        mCur  = mQ.pop_front();
        mBusy = 1'b1;
        mIdx  = 0;
      end else if (done) begin
        mBusy = 1'b0;
      end else if (hs) begin
        mIdx++;
      end
      if (acc) mQ.push_back(result);
    end
  end

  function automatic logic [7:0] modelByte();
    if (!mBusy) return 8'h00;
    return 8'((mCur >> (8 * (7 - mIdx))) & 64'hFF);
  endfunction

  always @(negedge clk) begin
    checkOutput("cmp_valid", out_valid, mBusy);
    checkOutput("cmp_data",  out_data, modelByte());
    checkOutput("cmp_last",  out_last, mBusy && (mIdx == 7));
    checkOutput("cmp_level", fifo_level, mQ.size());
    checkOutput("cmp_ovf",   overflow, mOvf);
`ifdef DES_OUT_DROPCNT_EN
    checkOutput("cmp_drop",  drop_count, mDrop);
`endif
  end

  // Handshake capture, sampled half a cycle before the accepting edge.
  logic [7:0] capData[$];
  bit         capLast[$];
  int         capCycle[$];
  int         cycleNo = 0;
  int         peakLevel = 0;

  always @(negedge clk) begin
    cycleNo++;
    if (int'(fifo_level) > peakLevel) peakLevel = int'(fifo_level);
    if (rst && !flush && out_valid && out_ready) begin
      capData.push_back(out_data);
      capLast.push_back(out_last);
      capCycle.push_back(cycleNo);
    end
  end

  task automatic clearCaps();
    capData.delete();
    capLast.delete();
    capCycle.delete();
    peakLevel = 0;
  endtask

  task automatic applyStimulus(input bit rv, input logic [63:0] res, input bit rdy, input bit fl);
    result_valid = rv;
    result       = rv ? res : 64'hDEAD_BEEF_0BAD_F00D;
    out_ready    = rdy;
    flush        = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) applyStimulus(1'b0, 64'h0, rdy, 1'b0);
  endtask

  function automatic logic [63:0] blk(input int k);
    return {8'(k), 48'hA1B2C3D4E5F6, 8'(k)};
  endfunction

  function automatic logic [63:0] capWord(input int b);
    logic [63:0] w = '0;
    for (int j = 0; j < 8; j++) w = {w[55:0], capData[b*8 + j]};
    return w;
  endfunction

  localparam logic [63:0] BLK_A = 64'hC95744256A5ED31D;
  localparam logic [63:0] BLK_P = 64'h5555AAAA5555AAAA;
  localparam logic [63:0] BLK_F = 64'h0F1E2D3C4B5A6978;

  logic [7:0] expA [8] = '{8'hC9, 8'h57, 8'h44, 8'h25, 8'h6A, 8'h5E, 8'hD3, 8'h1D};
  logic [7:0] expB [16] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF,
                            8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  int lastCount;

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_data",  out_data, 0);
    checkOutput("rst_last",  out_last, 0);
    checkOutput("rst_level", fifo_level, 0);
    checkOutput("rst_ovf",   overflow, 0);
    rst = 1'b1;
    idle(2, 1'b1);

    $display("[TB] single block");
    clearCaps();
    applyStimulus(1'b1, BLK_A, 1'b1, 1'b0);
    checkOutput("lat_e0_valid", out_valid, 0);
    checkOutput("lat_e0_level", fifo_level, 1);
    idle(1, 1'b1);
    checkOutput("lat_e1_valid", out_valid, 1);
    checkOutput("lat_e1_data",  out_data, 8'hC9);
    checkOutput("lat_e1_level", fifo_level, 0);
    idle(10, 1'b1);
    checkOutput("single_count", capData.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < capData.size()) begin
        checkOutput($sformatf("single_byte%0d", i), capData[i], expA[i]);
        checkOutput($sformatf("single_last%0d", i), capLast[i], (i == 7));
      end
    end
    if (capCycle.size() == 8) checkOutput("single_contig", capCycle[7] - capCycle[0], 7);
    checkOutput("single_idle", out_valid, 0);

    $display("[TB] backpressure");
    clearCaps();
    applyStimulus(1'b1, BLK_A, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) idle(1, (i % 4 == 0) || (i % 4 == 3));
    checkOutput("bp_count", capData.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < capData.size()) checkOutput($sformatf("bp_byte%0d", i), capData[i], expA[i]);
    end

    $display("[TB] back-to-back");
    idle(2, 1'b1);
    clearCaps();
    applyStimulus(1'b1, 64'h0123456789ABCDEF, 1'b1, 1'b0);
    applyStimulus(1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0);
    idle(20, 1'b1);
    checkOutput("b2b_count", capData.size(), 16);
    lastCount = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < capData.size()) begin
        checkOutput($sformatf("b2b_byte%0d", i), capData[i], expB[i]);
        if (capLast[i]) lastCount++;
      end
    end
    checkOutput("b2b_lasts", lastCount, 2);
    if (capData.size() == 16) begin
      checkOutput("b2b_last8",  capLast[7], 1);
      checkOutput("b2b_last16", capLast[15], 1);
      checkOutput("b2b_contig", capCycle[15] - capCycle[0], 15);
    end
    checkOutput("b2b_peak", peakLevel, 1);

    $display("[TB] overflow");
    clearCaps();
    applyStimulus(1'b1, BLK_P, 1'b0, 1'b0);
    idle(1, 1'b0);
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, blk(k), 1'b0, 1'b0);
    checkOutput("ovf_level", fifo_level, 8);
    checkOutput("ovf_flag",  overflow, 1);
`ifdef DES_OUT_DROPCNT_EN
    checkOutput("ovf_dropcnt", drop_count, 2);
`endif
    idle(80, 1'b1);
    checkOutput("ovf_count", capData.size(), 72);
    if (capData.size() == 72) begin
      checkOutput("ovf_blk_pre", capWord(0), BLK_P);
      for (int b = 1; b < 9; b++) checkOutput($sformatf("ovf_blk%0d", b - 1), capWord(b), blk(b - 1));
    end
    checkOutput("ovf_sticky", overflow, 1);

    $display("[TB] full with simultaneous pop");
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
    checkOutput("fl1_level", fifo_level, 0);
    checkOutput("fl1_ovf",   overflow, 0);
`ifdef DES_OUT_DROPCNT_EN
    checkOutput("fl1_dropcnt", drop_count, 0);
`endif
    clearCaps();
    applyStimulus(1'b1, BLK_P, 1'b0, 1'b0);
    idle(1, 1'b0);
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, blk(k + 20), 1'b0, 1'b0);
    checkOutput("full_level", fifo_level, 8);
    checkOutput("full_ovf",   overflow, 0);
    idle(7, 1'b1);
    checkOutput("full_lastbyte", out_last, 1);
    applyStimulus(1'b1, blk(99), 1'b1, 1'b0);
    checkOutput("fullpop_level", fifo_level, 8);
    checkOutput("fullpop_ovf",   overflow, 0);
    checkOutput("fullpop_data",  out_data, 8'h14);
    idle(85, 1'b1);
    checkOutput("fullpop_count", capData.size(), 80);
    if (capData.size() == 80) checkOutput("fullpop_tail", capWord(9), blk(99));

    $display("[TB] flush mid-block");
    clearCaps();
    applyStimulus(1'b1, BLK_F, 1'b1, 1'b0);
    idle(3, 1'b1);
    checkOutput("fl_byte3", out_data, 8'h2D);
    applyStimulus(1'b1, 64'h1, 1'b1, 1'b1);
    checkOutput("fl_valid", out_valid, 0);
    checkOutput("fl_level", fifo_level, 0);
    checkOutput("fl_ovf",   overflow, 0);
    checkOutput("fl_last",  out_last, 0);
    idle(5, 1'b1);
    checkOutput("fl_quiet", out_valid, 0);
    checkOutput("fl_caps",  capData.size(), 2);
    lastCount = 0;
    foreach (capLast[i]) if (capLast[i]) lastCount++;
    checkOutput("fl_nolast", lastCount, 0);

    $display("[TB] reset mid-block");
    clearCaps();
    applyStimulus(1'b1, BLK_F, 1'b1, 1'b0);
    idle(3, 1'b1);
    result_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    checkOutput("rs_valid", out_valid, 0);
    checkOutput("rs_level", fifo_level, 0);
    checkOutput("rs_ovf",   overflow, 0);
    checkOutput("rs_data",  out_data, 0);
    applyStimulus(1'b1, BLK_A, 1'b1, 1'b0);
    applyStimulus(1'b1, BLK_A, 1'b1, 1'b0);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
    rst = 1'b1;
    idle(4, 1'b1);
    checkOutput("rs_quiet", out_valid, 0);
    checkOutput("rs_level2", fifo_level, 0);
    lastCount = 0;
    foreach (capLast[i]) if (capLast[i]) lastCount++;
    checkOutput("rs_nolast", lastCount, 0);

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
